// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU memory interface: single-port word array
// with a wait-state read path and one-cycle write acknowledge.
module cpu_mem_responder #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2048,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              busy,
  output logic              err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [2:0]      WAIT_INIT = 3'(READ_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  rd_idx;
  logic [2:0]        wait_cnt;

  logic in_range;
  logic reject;
  logic accept_write;
  logic accept_read;

  // Requests are only looked at in IDLE; anything arriving while busy is dropped.
  always_comb begin
    in_range     = ({1'b0, addr} < DEPTH_L);
    reject       = 1'b0;
    accept_write = 1'b0;
    accept_read  = 1'b0;
    if (state == S_IDLE) begin
      reject       = (read_mem || write_mem) && ((read_mem && write_mem) || !in_range);
      accept_write = write_mem && !read_mem && in_range;
      accept_read  = read_mem && !write_mem && in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_write) mem[addr[IDX_W-1:0]] <= wdata;
  end

  // The wait counter reaching 1 hands off to RESP, which performs the array read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      rdata    <= '0;
      rvalid   <= 1'b0;
      wack     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= 3'd0;
      rd_idx   <= '0;
    end else begin
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reject) begin
            err <= 1'b1;
          end else if (accept_write) begin
            wack <= 1'b1;
          end else if (accept_read) begin
            rd_idx <= addr[IDX_W-1:0];
            busy   <= 1'b1;
            if (WAIT_INIT == 3'd0) begin
              state <= S_RESP;
            end else begin
              wait_cnt <= WAIT_INIT;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt <= 3'd1) begin
            wait_cnt <= 3'd0;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_RESP: begin
          rdata  <= mem[rd_idx];
          rvalid <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a per-cycle vector table on a 12-bit
// address instance plus reset-abort and READ_WAIT sweep sequences.
module tb_cpu_mem_responder;

  logic        clk;
  logic        resetn;
  logic        read_mem, write_mem;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid, wack, busy, err;

  logic        sw_read, sw_write;
  logic [10:0] sw_addr;
  logic [31:0] sw_wdata;
  logic [31:0] rdata0, rdata7;
  logic        rvalid0, wack0, busy0, err0;
  logic        rvalid7, wack7, busy7, err7;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder #(.ADDR_W(12), .DATA_W(32), .DEPTH(2048), .READ_WAIT(1)) dut (
    .clk(clk), .resetn(resetn), .read_mem(read_mem), .write_mem(write_mem),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .wack(wack),
    .busy(busy), .err(err)
  );

  cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .DEPTH(2048), .READ_WAIT(0)) dut_w0 (
    .clk(clk), .resetn(resetn), .read_mem(sw_read), .write_mem(sw_write),
    .addr(sw_addr), .wdata(sw_wdata), .rdata(rdata0), .rvalid(rvalid0), .wack(wack0),
    .busy(busy0), .err(err0)
  );

  cpu_mem_responder #(.ADDR_W(11), .DATA_W(32), .DEPTH(2048), .READ_WAIT(7)) dut_w7 (
    .clk(clk), .resetn(resetn), .read_mem(sw_read), .write_mem(sw_write),
    .addr(sw_addr), .wdata(sw_wdata), .rdata(rdata7), .rvalid(rvalid7), .wack(wack7),
    .busy(busy7), .err(err7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic        rv;
    logic        wk;
    logic        bz;
    logic        er;
    logic [31:0] rdv;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(logic rd, logic wr, logic [11:0] a, logic [31:0] wd,
                              logic rv, logic wk, logic bz, logic er, logic [31:0] rdv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.rv = rv; v.wk = wk; v.bz = bz; v.er = er; v.rdv = rdv;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [11:0] a,
                                input logic [31:0] wd);
    read_mem  = rd;
    write_mem = wr;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic check_all(input string tag, input logic rv, input logic wk, input logic bz,
                           input logic er, input logic [31:0] rdv);
    check_output({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, rv});
    check_output({tag, ".wack"},   {31'd0, wack},   {31'd0, wk});
    check_output({tag, ".busy"},   {31'd0, busy},   {31'd0, bz});
    check_output({tag, ".err"},    {31'd0, err},    {31'd0, er});
    check_output({tag, ".rdata"},  rdata,           rdv);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat0, lat7, rv_seen;

    vecs[0]  = mk(0, 0, 12'd0,    32'h0,        0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 12'd5,    32'hDEADBEEF, 0, 1, 0, 0, 32'h0);
    vecs[2]  = mk(1, 0, 12'd5,    32'h0,        0, 0, 1, 0, 32'h0);
    vecs[3]  = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'h0);
    vecs[4]  = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'hDEADBEEF);
    vecs[5]  = mk(0, 1, 12'd3,    32'h11112222, 0, 1, 0, 0, 32'hDEADBEEF);
    vecs[6]  = mk(1, 1, 12'd3,    32'h00000BAD, 0, 0, 0, 1, 32'hDEADBEEF);
    vecs[7]  = mk(1, 0, 12'd3,    32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
    vecs[8]  = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
    vecs[9]  = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'h11112222);
    vecs[10] = mk(0, 1, 12'd2047, 32'hCAFEF00D, 0, 1, 0, 0, 32'h11112222);
    vecs[11] = mk(1, 0, 12'd2047, 32'h0,        0, 0, 1, 0, 32'h11112222);
    vecs[12] = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'h11112222);
    vecs[13] = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'hCAFEF00D);
    vecs[14] = mk(1, 0, 12'd2048, 32'h0,        0, 0, 0, 1, 32'hCAFEF00D);
    vecs[15] = mk(0, 1, 12'd2048, 32'h55555555, 0, 0, 0, 1, 32'hCAFEF00D);
    vecs[16] = mk(0, 0, 12'd0,    32'h0,        0, 0, 0, 0, 32'hCAFEF00D);
    vecs[17] = mk(0, 1, 12'd7,    32'h77777777, 0, 1, 0, 0, 32'hCAFEF00D);
    vecs[18] = mk(1, 0, 12'd5,    32'h0,        0, 0, 1, 0, 32'hCAFEF00D);
    vecs[19] = mk(0, 1, 12'd7,    32'h12345678, 0, 0, 1, 0, 32'hCAFEF00D);
    vecs[20] = mk(0, 1, 12'd7,    32'h12345678, 1, 0, 0, 0, 32'hDEADBEEF);
    vecs[21] = mk(1, 0, 12'd7,    32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
    vecs[22] = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'hDEADBEEF);
    vecs[23] = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'h77777777);
    vecs[24] = mk(0, 1, 12'd9,    32'hA5A5A5A5, 0, 1, 0, 0, 32'h77777777);
    vecs[25] = mk(1, 0, 12'd9,    32'h0,        0, 0, 1, 0, 32'h77777777);
    vecs[26] = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'h77777777);
    vecs[27] = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'hA5A5A5A5);
    vecs[28] = mk(0, 1, 12'd10,   32'h00000001, 0, 1, 0, 0, 32'hA5A5A5A5);
    vecs[29] = mk(0, 1, 12'd11,   32'h00000002, 0, 1, 0, 0, 32'hA5A5A5A5);
    vecs[30] = mk(1, 0, 12'd10,   32'h0,        0, 0, 1, 0, 32'hA5A5A5A5);
    vecs[31] = mk(0, 0, 12'd0,    32'h0,        0, 0, 1, 0, 32'hA5A5A5A5);
    vecs[32] = mk(0, 0, 12'd0,    32'h0,        1, 0, 0, 0, 32'h00000001);

    resetn = 1'b0;
    apply_stimulus(0, 0, 12'd0, 32'h0);
    sw_read = 1'b0; sw_write = 1'b0; sw_addr = '0; sw_wdata = '0;

    // Reset held with requests toggling, then idle after release
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all($sformatf("reset_hold%0d", i), 0, 0, 0, 0, 32'h0);
      apply_stimulus(i[0], ~i[0], 12'(i + 1), 32'hFFFF0000 | i);
    end
    @(negedge clk);
    apply_stimulus(0, 0, 12'd0, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all($sformatf("post_reset%0d", i), 0, 0, 0, 0, 32'h0);
    end

    for (int i = 0; i < 33; i++) begin
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].rv, vecs[i].wk, vecs[i].bz, vecs[i].er, vecs[i].rdv);
    end
    apply_stimulus(0, 0, 12'd0, 32'h0);

    // Reset asserted while a read sits in WAIT must swallow the response
    @(negedge clk);
    apply_stimulus(1, 0, 12'd5, 32'h0);
    @(negedge clk);
    apply_stimulus(0, 0, 12'd0, 32'h0);
    check_output("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1 check_all("abort_in_reset", 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn  = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid) rv_seen++;
    end
    check_output("abort_no_rvalid", rv_seen, 32'd0);

    apply_stimulus(1, 0, 12'd5, 32'h0);
    lat = -1;
    for (int k = 0; k < 16 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) apply_stimulus(0, 0, 12'd0, 32'h0);
      if (rvalid) lat = k;
    end
    check_output("after_abort_latency", lat, 32'd2);
    check_output("after_abort_rdata", rdata, 32'hDEADBEEF);

    // READ_WAIT sweep: write, then read with a write to the same word while busy
    sw_write = 1'b1; sw_addr = 11'd7; sw_wdata = 32'h00000707;
    @(negedge clk);
    sw_write = 1'b0;
    check_output("sw0_wack", {31'd0, wack0}, 32'd1);
    check_output("sw7_wack", {31'd0, wack7}, 32'd1);
    @(negedge clk);

    for (int pass = 0; pass < 2; pass++) begin
      sw_read = 1'b1; sw_addr = 11'd7;
      lat0 = -1; lat7 = -1;
      for (int k = 0; k < 20 && (lat0 < 0 || lat7 < 0); k++) begin
        @(negedge clk);
        if (rvalid0 && lat0 < 0) lat0 = k;
        if (rvalid7 && lat7 < 0) lat7 = k;
        sw_read  = 1'b0;
        sw_write = (pass == 0 && k == 0);
        sw_wdata = 32'hBAADF00D;
      end
      sw_write = 1'b0;
      check_output($sformatf("sw0_latency_p%0d", pass), lat0, 32'd1);
      check_output($sformatf("sw7_latency_p%0d", pass), lat7, 32'd8);
      check_output($sformatf("sw0_rdata_p%0d", pass), rdata0, 32'h00000707);
      check_output($sformatf("sw7_rdata_p%0d", pass), rdata7, 32'h00000707);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
